// File: rtl/riscv_hwloop_unit.sv
// Hardware-loop unit for the RI5CY ID stage: loop register file, end-of-body
// detection with nested-loop priority, fetch redirect and loop-done pulses.
module riscv_hwloop_unit #(
    parameter int N_LOOPS = 2,
    parameter int ADDR_W  = 32,
    parameter int CNT_W   = 32,
    localparam int IDX_W  = (N_LOOPS > 1) ? $clog2(N_LOOPS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              pc_valid_i,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  wloop_i,
    input  logic [1:0]        wsel_i,
    input  logic [31:0]       wdata_i,
    input  logic [IDX_W-1:0]  rloop_i,
    input  logic [1:0]        rsel_i,
    output logic [31:0]       rdata_o,
    output logic              jump_o,
    output logic [ADDR_W-1:0] targ_o,
    output logic [N_LOOPS-1:0] active_o,
    output logic [N_LOOPS-1:0] done_o
);

    logic [ADDR_W-1:0]  start_r [N_LOOPS];
    logic [ADDR_W-1:0]  end_r   [N_LOOPS];
    logic [CNT_W-1:0]   cnt_r   [N_LOOPS];
    logic [N_LOOPS-1:0] done_r;

    logic [N_LOOPS-1:0] match_s;
    logic [N_LOOPS-1:0] win_s;
    logic [N_LOOPS-1:0] exit_s;
    logic [N_LOOPS-1:0] dec_s;
    logic [N_LOOPS-1:0] wr_start_s;
    logic [N_LOOPS-1:0] wr_end_s;
    logic [N_LOOPS-1:0] wr_cnt_s;
    logic               found_s;
    logic [IDX_W-1:0]   win_idx_s;
    logic [31:0]        rdata_s;

    // Match detection and priority winner; loops below the winner with one
    // iteration left exit, loops above it are left alone.
    always_comb begin
        match_s   = '0;
        win_s     = '0;
        exit_s    = '0;
        dec_s     = '0;
        found_s   = 1'b0;
        win_idx_s = '0;
        for (int i = 0; i < N_LOOPS; i++) begin
            match_s[i] = pc_valid_i && (pc_i == end_r[i]) && (cnt_r[i] != '0);
            exit_s[i]  = !found_s && match_s[i] && (cnt_r[i] == CNT_W'(1));
            win_s[i]   = !found_s && match_s[i] && (cnt_r[i] >= CNT_W'(2));
            win_idx_s  = win_s[i] ? IDX_W'(i) : win_idx_s;
            found_s    = found_s | win_s[i];
        end
        dec_s = win_s;
    end

    // Setup-port write decode.
    always_comb begin
        wr_start_s = '0;
        wr_end_s   = '0;
        wr_cnt_s   = '0;
        for (int i = 0; i < N_LOOPS; i++) begin
            wr_start_s[i] = we_i && (wloop_i == IDX_W'(i)) && (wsel_i == 2'b00);
            wr_end_s[i]   = we_i && (wloop_i == IDX_W'(i)) && (wsel_i == 2'b01);
            wr_cnt_s[i]   = we_i && (wloop_i == IDX_W'(i)) && (wsel_i == 2'b10);
        end
    end

    // Loop register file and done pulses; a counter write overrides any
    // decrement or exit of the same loop on that edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_LOOPS; i++) begin
                start_r[i] <= '0;
                end_r[i]   <= '0;
                cnt_r[i]   <= '0;
            end
            done_r <= '0;
        end else begin
            for (int i = 0; i < N_LOOPS; i++) begin
                done_r[i] <= 1'b0;
                if (wr_start_s[i]) begin
                    start_r[i] <= wdata_i[ADDR_W-1:0];
                end
                if (wr_end_s[i]) begin
                    end_r[i] <= wdata_i[ADDR_W-1:0];
                end
                if (wr_cnt_s[i]) begin
                    cnt_r[i] <= wdata_i[CNT_W-1:0];
                end else if (dec_s[i]) begin
                    cnt_r[i] <= cnt_r[i] - CNT_W'(1);
                end else if (exit_s[i]) begin
                    cnt_r[i]  <= '0;
                    done_r[i] <= 1'b1;
                end
            end
        end
    end

    // Readback mux, zero-extended; reserved select and out-of-range index read 0.
    always_comb begin
        rdata_s = 32'd0;
        if (int'(rloop_i) < N_LOOPS) begin
            case (rsel_i)
                2'b00:   rdata_s = 32'(start_r[rloop_i]);
                2'b01:   rdata_s = 32'(end_r[rloop_i]);
                2'b10:   rdata_s = 32'(cnt_r[rloop_i]);
                default: rdata_s = 32'd0;
            endcase
        end else begin
            rdata_s = 32'd0;
        end
    end

    // Status vector straight from the counters.
    always_comb begin
        active_o = '0;
        for (int i = 0; i < N_LOOPS; i++) begin
            active_o[i] = (cnt_r[i] != '0);
        end
    end

    assign rdata_o = rdata_s;
    assign jump_o  = found_s;
    assign targ_o  = found_s ? start_r[win_idx_s] : '0;
    assign done_o  = done_r;

endmodule

// File: tb/tb_riscv_hwloop_unit.sv
// Directed self-checking bench for riscv_hwloop_unit with N_LOOPS = 2.
module tb_riscv_hwloop_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_i = 32'd0;
    logic        pc_valid_i = 1'b0;
    logic        we_i = 1'b0;
    logic [0:0]  wloop_i = 1'b0;
    logic [1:0]  wsel_i = 2'b00;
    logic [31:0] wdata_i = 32'd0;
    logic [0:0]  rloop_i = 1'b0;
    logic [1:0]  rsel_i = 2'b00;
    logic [31:0] rdata_o;
    logic        jump_o;
    logic [31:0] targ_o;
    logic [1:0]  active_o;
    logic [1:0]  done_o;

    int n_checks = 0;
    int n_fail   = 0;

    riscv_hwloop_unit #(.N_LOOPS(2), .ADDR_W(32), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .pc_i(pc_i), .pc_valid_i(pc_valid_i),
        .we_i(we_i), .wloop_i(wloop_i), .wsel_i(wsel_i), .wdata_i(wdata_i),
        .rloop_i(rloop_i), .rsel_i(rsel_i), .rdata_o(rdata_o),
        .jump_o(jump_o), .targ_o(targ_o), .active_o(active_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int l, input logic [1:0] s, input logic [31:0] d);
        we_i = 1'b1; wloop_i = 1'(l); wsel_i = s; wdata_i = d;
        tick();
        we_i = 1'b0;
    endtask

    task automatic rd(input int l, input logic [1:0] s, output logic [31:0] v);
        rloop_i = 1'(l); rsel_i = s;
        @(negedge clk);
        v = rdata_o;
    endtask

    // Issue one PC; check the combinational redirect, then done_o after the edge.
    task automatic issue(input string tag, input logic [31:0] pc, input logic ej,
                         input logic [31:0] et, input logic [1:0] ed);
        pc_i = pc; pc_valid_i = 1'b1;
        #1;
        check_eq({tag, "_jump"}, 32'(jump_o), 32'(ej));
        check_eq({tag, "_targ"}, targ_o, et);
        tick();
        pc_valid_i = 1'b0;
        check_eq({tag, "_done"}, 32'(done_o), 32'(ed));
    endtask

    logic [31:0] v;

    initial begin
        // 1. Reset
        #12 rst = 1'b0;
        tick();
        check_eq("rst_active", 32'(active_o), 32'd0);
        check_eq("rst_done", 32'(done_o), 32'd0);
        rd(0, 2'b10, v);
        check_eq("rst_cnt0", v, 32'd0);
        wr(0, 2'b00, 32'h0000_0008);
        wr(0, 2'b01, 32'h0000_0010);
        wr(0, 2'b10, 32'd5);
        pc_i = 32'h10; pc_valid_i = 1'b1;
        #1;
        check_eq("pre_rst_jump", 32'(jump_o), 32'd1);
        check_eq("pre_rst_active", 32'(active_o), 32'd1);
        #1 rst = 1'b1;
        #1;
        check_eq("async_rst_jump", 32'(jump_o), 32'd0);
        check_eq("async_rst_targ", targ_o, 32'd0);
        check_eq("async_rst_active", 32'(active_o), 32'd0);
        pc_valid_i = 1'b0;
        @(negedge clk) rst = 1'b0;
        rd(0, 2'b10, v);
        check_eq("post_rst_cnt0", v, 32'd0);
        rd(0, 2'b01, v);
        check_eq("post_rst_end0", v, 32'd0);

        // 2. Single loop, three iterations
        wr(0, 2'b00, 32'h100);
        wr(0, 2'b01, 32'h10C);
        wr(0, 2'b10, 32'd3);
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < 4; k++) begin
                issue($sformatf("t2_p%0d_k%0d", p, k), 32'h100 + 32'(4 * k),
                      (k == 3 && p < 2), (k == 3 && p < 2) ? 32'h100 : 32'd0,
                      (k == 3 && p == 2) ? 2'b01 : 2'b00);
            end
        end
        tick();
        check_eq("t2_done_clr", 32'(done_o), 32'd0);
        rd(0, 2'b10, v);
        check_eq("t2_cnt0", v, 32'd0);
        check_eq("t2_active", 32'(active_o), 32'd0);

        // 3. Shared end address, nested
        wr(0, 2'b00, 32'h1F0);
        wr(0, 2'b01, 32'h200);
        wr(0, 2'b10, 32'd2);
        wr(1, 2'b00, 32'h1E0);
        wr(1, 2'b01, 32'h200);
        wr(1, 2'b10, 32'd2);
        issue("t3_a", 32'h200, 1'b1, 32'h1F0, 2'b00);
        rd(1, 2'b10, v);
        check_eq("t3_cnt1_untouched", v, 32'd2);
        issue("t3_b", 32'h200, 1'b1, 32'h1E0, 2'b01);
        wr(0, 2'b10, 32'd2);
        issue("t3_c", 32'h200, 1'b1, 32'h1F0, 2'b00);
        issue("t3_d", 32'h200, 1'b0, 32'd0, 2'b11);
        check_eq("t3_active", 32'(active_o), 32'd0);

        // 4. Stall holds state
        wr(0, 2'b00, 32'h300);
        wr(0, 2'b01, 32'h30C);
        wr(0, 2'b10, 32'd3);
        pc_i = 32'h30C; pc_valid_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            check_eq($sformatf("t4_stall%0d_jump", c), 32'(jump_o), 32'd0);
            tick();
        end
        issue("t4_go", 32'h30C, 1'b1, 32'h300, 2'b00);
        rd(0, 2'b10, v);
        check_eq("t4_cnt0", v, 32'd2);

        // 5. Counter write collides with exit
        wr(0, 2'b00, 32'h3F0);
        wr(0, 2'b01, 32'h400);
        wr(0, 2'b10, 32'd1);
        pc_i = 32'h400; pc_valid_i = 1'b1;
        we_i = 1'b1; wloop_i = 1'b0; wsel_i = 2'b10; wdata_i = 32'd7;
        #1;
        check_eq("t5_jump", 32'(jump_o), 32'd0);
        tick();
        we_i = 1'b0; pc_valid_i = 1'b0;
        check_eq("t5_done", 32'(done_o), 32'd0);
        check_eq("t5_active", 32'(active_o), 32'd1);
        rd(0, 2'b10, v);
        check_eq("t5_cnt0", v, 32'd7);

        // 6. cnt = 1 entry and reserved select
        wr(0, 2'b00, 32'h500);
        wr(0, 2'b01, 32'h508);
        wr(0, 2'b10, 32'd1);
        wr(0, 2'b11, 32'hDEAD_BEEF);
        wr(1, 2'b11, 32'hDEAD_BEEF);
        rd(0, 2'b00, v); check_eq("t6_start0", v, 32'h500);
        rd(0, 2'b01, v); check_eq("t6_end0", v, 32'h508);
        rd(0, 2'b10, v); check_eq("t6_cnt0", v, 32'd1);
        rd(1, 2'b00, v); check_eq("t6_start1", v, 32'h1E0);
        rd(1, 2'b01, v); check_eq("t6_end1", v, 32'h200);
        rd(1, 2'b10, v); check_eq("t6_cnt1", v, 32'd0);
        rd(0, 2'b11, v); check_eq("t6_rsv_read", v, 32'd0);
        issue("t6_a", 32'h500, 1'b0, 32'd0, 2'b00);
        issue("t6_b", 32'h504, 1'b0, 32'd0, 2'b00);
        issue("t6_c", 32'h508, 1'b0, 32'd0, 2'b01);
        issue("t6_d", 32'h500, 1'b0, 32'd0, 2'b00);
        rd(0, 2'b10, v);
        check_eq("t6_cnt0_end", v, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
